// File: rtl/axis_header_insert_sched.sv
// Frame-level round-robin front end for one header-insert datapath: header then payload per grant.
// Grant registered 1 cycle after request; valid/ready/data pass through combinationally. Optional per-source frame counters under AXIS_HDR_SCHED_STATS_EN.
module axis_header_insert_sched #(
  parameter int NUM_SRC         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH),
  parameter int ID_WIDTH        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    s_valid_insert,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]         s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WIDTH-1:0]    s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WIDTH-1:0]     s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]                    s_ready_insert,
  input  logic [NUM_SRC-1:0]                    s_valid_in,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]         s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WIDTH-1:0]    s_keep_in,
  input  logic [NUM_SRC-1:0]                    s_last_in,
  output logic [NUM_SRC-1:0]                    s_ready_in,
  output logic                                  m_valid_insert,
  output logic [DATA_WIDTH-1:0]                 m_data_insert,
  output logic [DATA_BYTE_WIDTH-1:0]            m_keep_insert,
  output logic [BYTE_CNT_WIDTH-1:0]             m_byte_insert_cnt,
  input  logic                                  m_ready_insert,
  output logic                                  m_valid_in,
  output logic [DATA_WIDTH-1:0]                 m_data_in,
  output logic [DATA_BYTE_WIDTH-1:0]            m_keep_in,
  output logic                                  m_last_in,
  input  logic                                  m_ready_in,
  output logic [ID_WIDTH-1:0]                   grant_id,
  output logic                                  busy
`ifdef AXIS_HDR_SCHED_STATS_EN
  ,output logic [NUM_SRC*16-1:0]                frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;

  logic [ID_WIDTH-1:0] win;
  logic                win_found;
  logic                hdr_hs;
  logic                last_hs;
  int                  gi;

  assign gi       = int'(grant_q);
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign hdr_hs   = m_valid_insert & m_ready_insert;
  assign last_hs  = m_valid_in & m_ready_in & m_last_in;

  // Cyclic search for the first requester at or after the rr pointer.
  always_comb begin
    int idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (!win_found && s_valid_insert[idx]) begin
        win_found = 1'b1;
        win       = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win;
          state_d = HDR;
          busy_d  = 1'b1;
        end
      end
      HDR: begin
        if (hdr_hs) state_d = DATA;
      end
      DATA: begin
        if (last_hs) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rr_d    = (grant_q == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  // Only the granted source is muxed through; idle outputs are forced to zero.
  always_comb begin
    s_ready_insert    = '0;
    s_ready_in        = '0;
    m_valid_insert    = 1'b0;
    m_data_insert     = '0;
    m_keep_insert     = '0;
    m_byte_insert_cnt = '0;
    m_valid_in        = 1'b0;
    m_data_in         = '0;
    m_keep_in         = '0;
    m_last_in         = 1'b0;
    if (state_q == HDR) begin
      s_ready_insert[gi] = m_ready_insert;
      m_valid_insert     = s_valid_insert[gi];
      if (s_valid_insert[gi]) begin
        m_data_insert     = s_data_insert[gi*DATA_WIDTH +: DATA_WIDTH];
        m_keep_insert     = s_keep_insert[gi*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
        m_byte_insert_cnt = s_byte_insert_cnt[gi*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH];
      end
    end
    if (state_q == DATA) begin
      s_ready_in[gi] = m_ready_in;
      m_valid_in     = s_valid_in[gi];
      if (s_valid_in[gi]) begin
        m_data_in = s_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        m_keep_in = s_keep_in[gi*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
        m_last_in = s_last_in[gi];
      end
    end
  end

`ifdef AXIS_HDR_SCHED_STATS_EN
  logic [NUM_SRC*16-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == DATA && last_hs)
      frame_cnt_d[gi*16 +: 16] = frame_cnt_q[gi*16 +: 16] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_header_insert_sched.sv
// Randomized bench for axis_header_insert_sched against a frame-queue round-robin reference model.
module tb_axis_header_insert_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid_insert, s_ready_insert, s_valid_in, s_last_in, s_ready_in;
  logic [N*DW-1:0] s_data_insert, s_data_in;
  logic [N*KW-1:0] s_keep_insert, s_keep_in;
  logic [N*CW-1:0] s_byte_insert_cnt;
  logic            m_valid_insert, m_ready_insert, m_valid_in, m_last_in, m_ready_in, busy;
  logic [DW-1:0]   m_data_insert, m_data_in;
  logic [KW-1:0]   m_keep_insert, m_keep_in;
  logic [CW-1:0]   m_byte_insert_cnt;
  logic [IW-1:0]   grant_id;
`ifdef AXIS_HDR_SCHED_STATS_EN
  logic [N*16-1:0] frame_cnt;
`endif

  axis_header_insert_sched #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
    .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
    .s_ready_insert(s_ready_insert),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
    .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
    .m_ready_insert(m_ready_insert),
    .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
    .m_last_in(m_last_in), .m_ready_in(m_ready_in),
    .grant_id(grant_id), .busy(busy)
`ifdef AXIS_HDR_SCHED_STATS_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic [CW-1:0] c;} hdr_t;
  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;

  hdr_t  hq[N][$];
  beat_t bq[N][$];
  hdr_t  mh[N][$];
  beat_t mb[N][$];
  int    mrr, mcur, cyc, last_cyc, beats_seen;
  int    mframes[N];
  int    glog[$];
  int    hcyc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    bp_en, gap_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs(input logic [N-1:0] in_acc);
    for (int s = 0; s < N; s++) begin
      s_valid_insert[s] = (hq[s].size() > 0);
      s_data_insert[s*DW +: DW]     = (hq[s].size() > 0) ? hq[s][0].d : '0;
      s_keep_insert[s*KW +: KW]     = (hq[s].size() > 0) ? hq[s][0].k : '0;
      s_byte_insert_cnt[s*CW +: CW] = (hq[s].size() > 0) ? hq[s][0].c : '0;
      if (bq[s].size() == 0)              s_valid_in[s] = 1'b0;
      else if (s_valid_in[s] && !in_acc[s]) s_valid_in[s] = 1'b1;
      else                                s_valid_in[s] = gap_en ? ($urandom % 4 != 0) : 1'b1;
      s_data_in[s*DW +: DW] = (bq[s].size() > 0) ? bq[s][0].d : '0;
      s_keep_in[s*KW +: KW] = (bq[s].size() > 0) ? bq[s][0].k : '0;
      s_last_in[s]          = (bq[s].size() > 0) ? bq[s][0].l : 1'b0;
    end
  endtask

  task automatic load_frame(input int s, input logic [DW-1:0] hd, input int nb);
    hdr_t  h;
    beat_t x;
    h.d = hd; h.k = 4'($urandom); h.c = 2'($urandom);
    hq[s].push_back(h); mh[s].push_back(h);
    for (int b = 0; b < nb; b++) begin
      x.d = $urandom; x.k = 4'($urandom); x.l = (b == nb - 1);
      bq[s].push_back(x); mb[s].push_back(x);
    end
    drive_srcs('0);
  endtask

  // Reference: each header goes to the first source at/after the pointer with a pending frame.
  task automatic monitor();
    logic [N-1:0] oh;
    int src;
    hdr_t  eh;
    beat_t eb;
    oh = N'(1) << grant_id;
    check("ready_insert_excl", 64'(s_ready_insert & ~oh), 0);
    check("ready_in_excl", 64'(s_ready_in & ~oh), 0);
    if (m_valid_insert) begin
      check("ready_insert_mirror", 64'(s_ready_insert[grant_id]), 64'(m_ready_insert));
      check("valid_in_in_hdr", 64'(m_valid_in), 0);
      check("busy_hdr", 64'(busy), 1);
    end else check("hdr_data_zero", 64'(m_data_insert), 0);
    if (m_valid_in) begin
      check("ready_in_mirror", 64'(s_ready_in[grant_id]), 64'(m_ready_in));
      check("busy_data", 64'(busy), 1);
    end else check("in_data_zero", 64'(m_data_in), 0);
    if (m_valid_insert && m_ready_insert) begin
      src = -1;
      for (int k = 0; k < N; k++)
        if (src < 0 && mh[(mrr + k) % N].size() > 0) src = (mrr + k) % N;
      if (src < 0) check("hdr_unexpected", 1, 0);
      else begin
        eh = mh[src].pop_front();
        check("grant", 64'(grant_id), 64'(src));
        check("hdr_data", 64'(m_data_insert), 64'(eh.d));
        check("hdr_keep", 64'(m_keep_insert), 64'(eh.k));
        check("hdr_cnt", 64'(m_byte_insert_cnt), 64'(eh.c));
        mcur = src;
        glog.push_back(src);
        hcyc.push_back(cyc);
      end
    end
    if (m_valid_in && m_ready_in) begin
      if (mcur < 0 || mb[mcur < 0 ? 0 : mcur].size() == 0) check("beat_unexpected", 1, 0);
      else begin
        eb = mb[mcur].pop_front();
        check("beat_data", 64'(m_data_in), 64'(eb.d));
        check("beat_keep", 64'(m_keep_in), 64'(eb.k));
        check("beat_last", 64'(m_last_in), 64'(eb.l));
        beats_seen++;
        if (eb.l) begin
          last_cyc = cyc;
          mframes[mcur]++;
          mrr  = (mcur + 1) % N;
          mcur = -1;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] h_acc, i_acc;
    @(negedge clk);
    monitor();
    h_acc = s_valid_insert & s_ready_insert;
    i_acc = s_valid_in & s_ready_in;
    @(posedge clk); #1;
    cyc++;
    if (rst_n)
      for (int s = 0; s < N; s++) begin
        if (h_acc[s]) void'(hq[s].pop_front());
        if (i_acc[s]) void'(bq[s].pop_front());
      end
    m_ready_insert = bp_en ? 1'($urandom) : 1'b1;
    m_ready_in     = bp_en ? 1'($urandom) : 1'b1;
    drive_srcs(i_acc);
  endtask

  function automatic int pending();
    int t = 0;
    for (int s = 0; s < N; s++) t += hq[s].size() + bq[s].size() + mh[s].size() + mb[s].size();
    return t;
  endfunction

  task automatic drain(input int budget, input string tag);
    int i = 0;
    while (i < budget && !(pending() == 0 && !busy)) begin
      step();
      i++;
    end
    check(tag, 64'(i >= budget), 0);
  endtask

  task automatic clear_all();
    for (int s = 0; s < N; s++) begin
      hq[s].delete(); bq[s].delete(); mh[s].delete(); mb[s].delete();
      mframes[s] = 0;
    end
    mrr = 0; mcur = -1;
    s_valid_in = '0;
    drive_srcs('0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ready_insert = 1'b1; m_ready_in = 1'b1;
    bp_en = 1'b0; gap_en = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete(); hcyc.delete();
  endtask

  initial begin
    int c0, total;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    cyc = 0; beats_seen = 0; last_cyc = 0;
    s_valid_in = '0;
    do_reset();
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant_id), 0);
    check("rst_readies", 64'({s_ready_insert, s_ready_in}), 0);
    check("rst_valids", 64'({m_valid_insert, m_valid_in}), 0);
    @(posedge clk); #1;

    // Single source, 3-beat frame, then pointer must favour src1 over src0.
    c0 = cyc;
    load_frame(0, 32'hdeadbeef, 3);
    drain(100, "t1_drain");
    check("t1_grant", 64'(glog[0]), 0);
    check("t1_latency", 64'(hcyc[0] - c0), 1);
    check("t1_len", 64'(last_cyc - hcyc[0]), 3);
    load_frame(0, $urandom, 1);
    load_frame(1, $urandom, 1);
    drain(100, "t1b_drain");
    check("t1_ptr_next", 64'(glog[1]), 1);

    // All sources requesting, single-beat frames.
    do_reset();
    for (int s = 0; s < N; s++) load_frame(s, $urandom, 1);
    load_frame(0, $urandom, 1);
    drain(200, "t2_drain");
    check("t2_nframes", 64'(glog.size()), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check($sformatf("t2_order%0d", i), 64'(glog[i]), 64'(exp_order[i]));
    for (int i = 1; i < hcyc.size(); i++) check($sformatf("t2_gap%0d", i), 64'(hcyc[i] - hcyc[i-1]), 3);

    // Backpressure and payload gaps on a 5-beat src2 frame.
    do_reset();
    bp_en = 1'b1; gap_en = 1'b1; beats_seen = 0;
    load_frame(2, $urandom, 5);
    drain(500, "t3_drain");
    check("t3_beats", 64'(beats_seen), 5);

    // src1 request arrives while src3 owns the grant.
    do_reset();
    load_frame(3, $urandom, 6);
    repeat (3) step();
    load_frame(1, $urandom, 2);
    drain(200, "t4_drain");
    check("t4_first", 64'(glog[0]), 3);
    check("t4_second", 64'(glog.size() > 1 ? glog[1] : -1), 1);

    // Reset asserted during src1 payload.
    do_reset();
    load_frame(1, $urandom, 5);
    repeat (3) step();
    check("t5_busy_pre", 64'(busy), 1);
    rst_n = 1'b0; m_ready_in = 1'b0; m_ready_insert = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready_in = 1'b1; m_ready_insert = 1'b1;
    clear_all();
    @(negedge clk);
    check("t5_busy", 64'(busy), 0);
    check("t5_grant", 64'(grant_id), 0);
    check("t5_readies", 64'({s_ready_insert, s_ready_in}), 0);
    check("t5_valids", 64'({m_valid_insert, m_valid_in}), 0);
    @(posedge clk); #1;
    load_frame(2, $urandom, 2);
    drain(100, "t5_resume");

    // Random mix of frames on all sources with backpressure.
    do_reset();
    bp_en = 1'b1; gap_en = 1'b1; beats_seen = 0; total = 0;
    for (int s = 0; s < N; s++)
      for (int f = 0; f < int'($urandom_range(0, 4)); f++) begin
        int nb = $urandom_range(1, 6);
        load_frame(s, $urandom, nb);
        total += nb;
      end
    drain(5000, "t6_drain");
    check("t6_beats", 64'(beats_seen), 64'(total));
`ifdef AXIS_HDR_SCHED_STATS_EN
    for (int s = 0; s < N; s++) check($sformatf("frame_cnt%0d", s), 64'(frame_cnt[s*16 +: 16]), 64'(mframes[s] % 65536));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
